// File: rtl/sqrt_res_buf.sv
// Result FIFO behind the pipelined sqrt unit: FWFT registered output, afull, sticky ovf.
// Optional drop counter / high-water mark outputs when SQRT_BUF_STATS_EN is defined.
module sqrt_res_buf #(
  parameter int DW        = 16,
  parameter int DEPTH     = 32,
  parameter int AF_MARGIN = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [DW-1:0]            in_y,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DW-1:0]            out_y,
  output logic                     afull,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count
`ifdef SQRT_BUF_STATS_EN
  ,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_MARGIN);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] y_q, y_d;
  logic          vld_q, afull_q, ovf_q;
  logic          push, pop, drop, full;

  assign out_vld = vld_q;
  assign out_y   = y_q;
  assign afull   = afull_q;
  assign ovf     = ovf_q;
  assign count   = cnt_q;

  // Handshake decode, next pointers/count and the next head word.
  always_comb begin
    full  = (cnt_q == FULL);
    pop   = vld_q & out_rdy;
    push  = in_vld & (~full | pop);
    drop  = in_vld & full & ~pop;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + CW'(1);
      pop & ~push: cnt_d = cnt_q - CW'(1);
      default:     cnt_d = cnt_q;
    endcase
    // Head reloads when it is consumed or the FIFO was empty;
    // a word being written into the new head slot bypasses memory.
    y_d = y_q;
    if (cnt_d != '0 && (pop || cnt_q == '0)) begin
      if (push && wr_q == rd_d) y_d = in_y;
      else                      y_d = mem_q[rd_d];
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_y;
  end

  // Pointer, occupancy, registered output and flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      vld_q   <= (cnt_d != '0);
      afull_q <= (cnt_d >= AF_LVL);
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef SQRT_BUF_STATS_EN
  logic [15:0]   drop_cnt_q;
  logic [CW-1:0] hwm_q;

  assign drop_cnt = drop_cnt_q;
  assign hwm      = hwm_q;

  // Saturating drop counter and running occupancy maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      if (drop) begin
        if (ovf_clr)                   drop_cnt_q <= 16'd1;
        else if (drop_cnt_q != '1)     drop_cnt_q <= drop_cnt_q + 16'd1;
      end else if (ovf_clr) begin
        drop_cnt_q <= '0;
      end
      if (cnt_d > hwm_q) hwm_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_sqrt_res_buf.sv
// Randomized bench for sqrt_res_buf against a queue-based reference model.
// Stats outputs are checked when SQRT_BUF_STATS_EN is defined.
module tb_sqrt_res_buf;

  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AF_MARGIN = 17;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic [DW-1:0] in_y = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_y;
  logic          afull;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic [CW-1:0] count;
`ifdef SQRT_BUF_STATS_EN
  logic [15:0]   drop_cnt;
  logic [CW-1:0] hwm;
`endif

  sqrt_res_buf #(.DW(DW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_y(in_y),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y),
    .afull(afull), .ovf(ovf), .ovf_clr(ovf_clr), .count(count)
`ifdef SQRT_BUF_STATS_EN
    , .drop_cnt(drop_cnt), .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int q[$];
  bit m_ovf;
  int m_last;
  int m_drop;
  int m_hwm;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ovf = 0;
    m_last = 0;
    m_drop = 0;
    m_hwm = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic m_edge();
    int  sz;
    bit  p, w, d;
    sz = q.size();
    p = (sz > 0) && out_rdy;
    w = in_vld && (sz < DEPTH || p);
    d = in_vld && !w;
    if (p) void'(q.pop_front());
    if (w) q.push_back(int'(in_y));
    if (d) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (d) m_drop = ovf_clr ? 1 : (m_drop < 65535 ? m_drop + 1 : 65535);
    else if (ovf_clr) m_drop = 0;
    if (q.size() > m_hwm) m_hwm = q.size();
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_vld", 32'(out_vld), 32'(q.size() > 0));
    chk("out_y", 32'(out_y), 32'(m_last));
    chk("afull", 32'(afull), 32'(q.size() >= DEPTH - AF_MARGIN));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SQRT_BUF_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] y,
                     input logic r, input logic c);
    in_vld = v;
    in_y = y;
    out_rdy = r;
    ovf_clr = c;
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    #2;
    do_reset();

    // 1: back-to-back pass-through
    cyc(1, 16'd16, 1, 0);
    cyc(1, 16'd15, 1, 0);
    cyc(1, 16'd46340, 1, 0);
    cyc(1, 16'd65535, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // 2: afull threshold
    for (int i = 0; i < DEPTH - AF_MARGIN; i++) cyc(1, 16'(100 + i), 0, 0);
    cyc(0, 0, 1, 0);
    drain();

    // 3: overflow, clear, drain
    for (int i = 0; i <= DEPTH; i++) cyc(1, 16'(i), 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    drain();

    // 4: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'(200 + i), 0, 0);
    cyc(1, 16'hABCD, 1, 0);
    cyc(0, 0, 0, 0);
    drain();

    // 5: streaming with random stalls across pointer wrap
    for (int i = 0; i < 100; i++)
      cyc(1, 16'($urandom), 1'($urandom_range(0, 3) != 0), 0);
    drain();

    // fully random mix including overflow and clears
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    drain();

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) cyc(1, 16'(300 + i), 0, 0);
    #2;
    do_reset();
    cyc(1, 16'h1234, 1, 0);
    cyc(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_res_buf.md
Name: sqrt_res_buf

Overview:
- Result buffer directly downstream of the pipelined 32-bit integer square-root unit (`sqrt`).
- `sqrt` has no backpressure: it emits `vld_out`/`y[15:0]` whenever a result leaves its pipeline. This block captures every result into a FIFO and presents it to the consumer with valid/ready.
- Drives an almost-full flag so the upstream source can stop issuing `vld_in` to `sqrt` early enough to cover the in-flight pipeline depth.
- Flags any dropped result with a sticky overflow.

Parameters:
- DW, 16, data width; matches the `sqrt` result width.
- DEPTH, 32, FIFO entries; must be a power of 2, at least 4.
- AF_MARGIN, 17, free entries still remaining when `afull` asserts; equals `sqrt` pipeline latency + 1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  result valid; connect to `sqrt` `vld_out`
- in_y  input  DW  result data; connect to `sqrt` `y`
- out_vld  output  1  buffered result available
- out_rdy  input  1  consumer accepts `out_y` this cycle
- out_y  output  DW  head-of-FIFO result
- afull  output  1  occupancy >= DEPTH-AF_MARGIN; upstream must deassert `sqrt` `vld_in` while high
- ovf  output  1  sticky: a result was dropped
- ovf_clr  input  1  synchronous clear of `ovf`
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0):
  - rd/wr pointers=0, count=0.
  - out_vld=0, out_y=0, afull=0, ovf=0.
  - Memory contents are don't-care.
  - Reset mid-stream discards all buffered data; outputs take their reset values immediately.
- Push: `in_vld`=1 and (count<DEPTH, or pop in the same cycle). Writes `in_y` at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop: `out_vld`=1 and `out_rdy`=1. rd_ptr+1 mod DEPTH.
- count:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop.
- Full with simultaneous push and pop: both occur; count stays DEPTH.
- Empty with simultaneous push and pop: pop cannot occur (out_vld=0). Push is accepted; data appears on the next cycle.
- Drop: `in_vld`=1, count==DEPTH and no pop. Data discarded, pointers unchanged, `ovf` set next edge.
- `ovf`:
  - Stays set until `ovf_clr`=1.
  - If set and clear occur in the same cycle, set wins.
- Output is first-word fall-through and registered:
  - `out_vld`=1 iff count>0.
  - `out_y` = entry at rd_ptr, held stable while out_vld=1 and out_rdy=0.
  - A word pushed at edge N is visible on `out_vld`/`out_y` after edge N (single-cycle write-to-read latency).
  - While empty, `out_y` holds its last value (0 after reset).
- `afull`: registered, reflects count after the current edge. Asserts when count >= DEPTH-AF_MARGIN and deasserts when it falls below.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. FIFO order is preserved across wrap.
- No X on outputs after reset for any input sequence.

Optional Feature:
- Macro: SQRT_BUF_STATS_EN.
- Defined: adds two outputs, `drop_cnt[15:0]` and `hwm[$clog2(DEPTH):0]`.
  - `drop_cnt`: +1 per dropped result, saturates at 16'hFFFF, cleared by `ovf_clr` (an increment in the same cycle wins, giving 1).
  - `hwm`: maximum `count` seen since reset; never decreases.
  - Both reset to 0.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
1. Reset, then push `in_y` = 16, 15, 46340, 65535 on consecutive cycles with out_rdy=1 → out_y = 16, 15, 46340, 65535 in order, each one cycle after its push. count never exceeds 1. ovf=0.
2. out_rdy=0, push DEPTH−AF_MARGIN=15 words → afull rises after the 15th push edge. Pop one → afull falls.
3. out_rdy=0, push 33 words (0..32) → word 32 dropped, ovf=1, count=32. Drain → reads 0..31 exactly, out_vld drops after 32 pops.
4. Full FIFO with push+pop in the same cycle, value 0xABCD → no drop, ovf stays 0, count=32, 0xABCD later emerges last.
5. Continuous push/pop for 100 words with random out_rdy stalls → exact order preserved across pointer wrap, no loss while count<DEPTH, out_y stable during stalls.
6. Assert rst_n low mid-stream with count=10 → out_vld=0, count=0, afull=0, ovf=0 immediately. With SQRT_BUF_STATS_EN: after scenario 3, drop_cnt=1 and hwm=32; `ovf_clr` gives ovf=0, drop_cnt=0, and hwm still 32.
